// File: rtl/partition_seq_ctrl_pkg.sv
// Shared types for the ROM -> split-RAM partition sequencer.
// Optional feature macro: PARTITION_LOOP_EN (continuous playback).
package partition_pkg;

  // Sequencer phases; the order is the natural flow of one run.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    PLAY_L = 3'd2,
    PLAY_H = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Display mux selections.
  localparam logic [1:0] VIEW_ROM = 2'd0;
  localparam logic [1:0] VIEW_L   = 2'd1;
  localparam logic [1:0] VIEW_H   = 2'd2;

endpackage

// File: rtl/partition_seq_ctrl_if.sv
// Bus bundle between the partition sequencer and its ROM/RAM/display environment.
// master = sequencer side, slave = environment side (ROM, RAMs, display, host).
interface partition_seq_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] wr_data;
  logic [ADDR_W-1:0] raml_addr;
  logic              raml_we;
  logic [ADDR_W-1:0] ramh_addr;
  logic              ramh_we;
  logic [1:0]        view_sel;
  logic [ADDR_W:0]   l_count;
  logic [ADDR_W:0]   h_count;
  logic [ADDR_W:0]   drop_count;
  logic              busy;
  logic              done;

  modport master (
    input  start, rom_data,
    output rom_addr, wr_data, raml_addr, raml_we, ramh_addr, ramh_we,
           view_sel, l_count, h_count, drop_count, busy, done
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, wr_data, raml_addr, raml_we, ramh_addr, ramh_we,
           view_sel, l_count, h_count, drop_count, busy, done
  );
endinterface

// File: rtl/partition_seq_ctrl_dwell_timer.sv
// Dwell timer: holds each playback entry for DWELL cycles.
// load restarts the count at DWELL-1; tick is high on the last cycle of an entry.
module dwell_timer #(
  parameter int DWELL = 2
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic load,
  output logic tick
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt;

  // Down-counter that parks at zero until reloaded.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DWELL - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);
endmodule

// File: rtl/partition_seq_ctrl.sv
// Partition sequencer: scans the ROM once, splits valid words into low/high RAMs,
// then plays both RAMs back for display.
// Optional feature macro: PARTITION_LOOP_EN -- playback loops PLAY_L/PLAY_H forever,
// start during playback restarts the fill, DONE is never reached.
module partition_seq_ctrl
  import partition_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 8,
  parameter int THRESH = 50,
  parameter int LIMIT  = 100,
  parameter int DWELL  = 2
) (
  input  logic               CLK,
  input  logic               reset_n,
  partition_seq_ctrl_if.master bus
);
  localparam int CNT_W = ADDR_W + 1;

  state_t state, state_next;

  logic [ADDR_W-1:0] rom_addr, raml_addr, ramh_addr;
  logic [CNT_W-1:0]  l_count, h_count, drop_count;

  // Control strobes produced by the FSM and consumed by the datapath.
  logic       clr_run, rom_inc, l_inc, h_inc, d_inc;
  logic       raml_zero, raml_step, ramh_zero, ramh_step;
  logic       timer_load, tick;
  logic       raml_we, ramh_we;
  logic [1:0] view;

  // Word classification: values are zero-extended so any LIMIT/THRESH compare correctly.
  logic word_valid, word_gt;
  assign word_valid = (int'(bus.rom_data) < LIMIT);
  assign word_gt    = (int'(bus.rom_data) > THRESH);

  // Last entry of each playback list (pointer equals count-1).
  logic l_last, h_last, l_empty, h_empty, rom_last;
  assign l_last   = (CNT_W'(raml_addr) == l_count - CNT_W'(1));
  assign h_last   = (CNT_W'(ramh_addr) == h_count - CNT_W'(1));
  assign l_empty  = (l_count == '0);
  assign h_empty  = (h_count == '0);
  assign rom_last = (rom_addr == {ADDR_W{1'b1}});

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .CLK     (CLK),
    .reset_n (reset_n),
    .load    (timer_load),
    .tick    (tick)
  );

  // State register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic, write enables and datapath strobes.
  always_comb begin
    state_next = state;
    view       = VIEW_ROM;
    raml_we    = 1'b0;
    ramh_we    = 1'b0;
    clr_run    = 1'b0;
    rom_inc    = 1'b0;
    l_inc      = 1'b0;
    h_inc      = 1'b0;
    d_inc      = 1'b0;
    raml_zero  = 1'b0;
    raml_step  = 1'b0;
    ramh_zero  = 1'b0;
    ramh_step  = 1'b0;
    timer_load = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = FILL;
          clr_run    = 1'b1;
        end
      end
      FILL: begin
        // Write enables follow the ROM word combinationally; the pointer moves on the edge.
        rom_inc = 1'b1;
        if (word_valid && word_gt) begin
          ramh_we = 1'b1;
          h_inc   = 1'b1;
        end else if (word_valid) begin
          raml_we = 1'b1;
          l_inc   = 1'b1;
        end else begin
          d_inc = 1'b1;
        end
        if (rom_last) begin
          state_next = PLAY_L;
          raml_zero  = 1'b1;
          timer_load = 1'b1;
        end
      end
      PLAY_L: begin
        view = VIEW_L;
        if (l_empty || (tick && l_last)) begin
          state_next = PLAY_H;
          ramh_zero  = 1'b1;
          timer_load = 1'b1;
        end else if (tick) begin
          raml_step  = 1'b1;
          timer_load = 1'b1;
        end
`ifdef PARTITION_LOOP_EN
        if (bus.start) begin
          state_next = FILL;
          clr_run    = 1'b1;
          ramh_zero  = 1'b0;
          raml_step  = 1'b0;
          timer_load = 1'b0;
        end
`endif
      end
      PLAY_H: begin
        view = VIEW_H;
        if (h_empty || (tick && h_last)) begin
`ifdef PARTITION_LOOP_EN
          state_next = PLAY_L;
          raml_zero  = 1'b1;
          timer_load = 1'b1;
`else
          state_next = DONE;
`endif
        end else if (tick) begin
          ramh_step  = 1'b1;
          timer_load = 1'b1;
        end
`ifdef PARTITION_LOOP_EN
        if (bus.start) begin
          state_next = FILL;
          clr_run    = 1'b1;
          raml_zero  = 1'b0;
          ramh_step  = 1'b0;
          timer_load = 1'b0;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Address pointers: ROM scan plus RAM write/playback pointers.
  // Zeroing is listed last so a phase change wins over the final fill increment.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      raml_addr <= '0;
      ramh_addr <= '0;
    end else if (clr_run) begin
      rom_addr  <= '0;
      raml_addr <= '0;
      ramh_addr <= '0;
    end else begin
      if (rom_inc) rom_addr <= rom_addr + 1'b1;
      if (l_inc || raml_step) raml_addr <= raml_addr + 1'b1;
      if (h_inc || ramh_step) ramh_addr <= ramh_addr + 1'b1;
      if (raml_zero) raml_addr <= '0;
      if (ramh_zero) ramh_addr <= '0;
    end
  end

  // Per-run statistics; wide enough that a full ROM into one bin cannot overflow.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      l_count    <= '0;
      h_count    <= '0;
      drop_count <= '0;
    end else if (clr_run) begin
      l_count    <= '0;
      h_count    <= '0;
      drop_count <= '0;
    end else begin
      if (l_inc) l_count    <= l_count + 1'b1;
      if (h_inc) h_count    <= h_count + 1'b1;
      if (d_inc) drop_count <= drop_count + 1'b1;
    end
  end

  assign bus.rom_addr   = rom_addr;
  assign bus.wr_data    = bus.rom_data;
  assign bus.raml_addr  = raml_addr;
  assign bus.raml_we    = raml_we;
  assign bus.ramh_addr  = ramh_addr;
  assign bus.ramh_we    = ramh_we;
  assign bus.view_sel   = view;
  assign bus.l_count    = l_count;
  assign bus.h_count    = h_count;
  assign bus.drop_count = drop_count;
  assign bus.busy       = (state == FILL) || (state == PLAY_L) || (state == PLAY_H);
  assign bus.done       = (state == DONE);
endmodule
